mxv_sequencer: RTL and testbench
================================

# mxv_sequencer

Compute and retransmit sequencer for the matrix-vector engine. It sits after the command-field control unit. A PREPARE command starts the N×N by N×1 unsigned multiply-accumulate over the matrix and vector RAMs and writes N results into the result RAM. A RETR command serialises those results to the UART transmitter, 3 bytes per result, MSB first. Its done pulses feed the command FSM's unlock inputs.

## Interface
Parameters:
- MAX_N, 8: largest supported matrix dimension.
- DATA_W, 8: width of matrix and vector elements.
- ACC_W, 19: accumulator and result width; must be ≥ 2·DATA_W + clog2(MAX_N).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse, from the PREPARE flag.
- retr  in  1  one-cycle pulse, from the RETR flag.
- n_size  in  4  dimension N; valid range 1..MAX_N.
- mat_addr  out  clog2(MAX_N²)  matrix RAM read address, row·MAX_N + col.
- mat_data  in  DATA_W  matrix RAM read data; 1-cycle read latency.
- vec_addr  out  clog2(MAX_N)  vector RAM read address, col.
- vec_data  in  DATA_W  vector RAM read data; 1-cycle read latency.
- res_addr  out  clog2(MAX_N)  result RAM address, shared by reads and writes.
- res_we  out  1  result RAM write enable.
- res_wdata  out  ACC_W  result RAM write data.
- res_rdata  in  ACC_W  result RAM read data; 1-cycle read latency.
- tx_start  out  1  one-cycle send request to the UART TX.
- tx_data  out  8  byte to send; valid while tx_start is high.
- tx_busy  in  1  registered UART TX busy; goes high the cycle after tx_start.
- busy  out  1  high in every state except IDLE.
- done_compute  out  1  one-cycle pulse; drives the PREPARE/RETR unlock.
- done_tx  out  1  one-cycle pulse at the end of transmission.
- err  out  1  one-cycle pulse on an invalid N or a RETR with no valid results.

## Operation
- States: IDLE, C_FETCH, C_DRAIN, C_WRITE, C_DONE, T_RD, T_LOAD, T_SEND, T_WAIT, T_DONE, ERR.
- Outputs are decoded from the state (Moore style). Address outputs come from the row/col/byte counters.
- IDLE, start=1:
  - n_size is latched as N.
  - If N=0 or N>MAX_N, go to ERR.
  - Otherwise clear row, col, acc and res_valid, then go to C_FETCH.
- C_FETCH:
  - Issue mat_addr/vec_addr for (row, col).
  - When col>0, acc += mat_data·vec_data, using the data for col−1.
  - col increments each cycle. At col=N−1, go to C_DRAIN.
- C_DRAIN: accumulate the last product, then go to C_WRITE.
- C_WRITE:
  - Assert res_we with res_addr=row and res_wdata=acc.
  - Clear acc and col, increment row.
  - Go to C_DONE if row=N−1, otherwise to C_FETCH.
- C_DONE: pulse done_compute, set res_valid, return to IDLE.
- IDLE, retr=1 (and start=0):
  - If res_valid=0, go to ERR.
  - Otherwise go to T_RD with row=0.
- T_RD: drive res_addr=row.
- T_LOAD: capture res_rdata, zero-extended to 24 bits, into the shift register; byte=0.
- T_SEND: pulse tx_start, with tx_data equal to the top byte of the shift register.
- T_WAIT:
  - Hold until tx_busy=0, then shift left 8 and increment byte.
  - After the 3rd byte: if row=N−1, go to T_DONE; otherwise increment row and go to T_RD.
- T_DONE: pulse done_tx, return to IDLE.
- ERR: pulse err.
  - If entered from start, also pulse done_compute in the same cycle.
  - If entered from retr, also pulse done_tx in the same cycle.
  - Return to IDLE.
- Arithmetic is unsigned. Products are 2·DATA_W bits, zero-extended to ACC_W. Overflow is impossible by the ACC_W rule.
- start and retr arriving together in IDLE: start wins and retr is dropped.
- start or retr outside IDLE is ignored. n_size changes after latching are ignored.
- res_valid is cleared by reset and by every accepted start, and set in C_DONE.

## Timing
- Reset values: every output 0, state IDLE, res_valid 0, all counters 0.
- Reset mid-operation has effect at the next edge: tx_start drops, no further res_we, res_valid is cleared.
- Cycle 0 is the cycle start is sampled. done_compute is high in cycle N·(N+2)+1.
- Invalid N: err and done_compute are high in cycle 1.
- Per result: 2 cycles (T_RD, T_LOAD), then per byte 1 cycle of T_SEND plus the T_WAIT cycles.
- tx_start is never asserted while tx_busy=1.

## Structure
- mxv_pkg holds:
  - the state enum;
  - the MAX_N, DATA_W and ACC_W defaults;
  - the TX_BYTES=3 constant.
- Sub-module mxv_mac is the natural split: multiplier plus accumulator register with clr/en controls, instantiated once.

## Test plan
- N=2, M=[[1,2],[3,4]], v=[5,6], start → res_we writes 17 at address 0 and 39 at address 1; done_compute in cycle 9.
- Then retr, with a TX model busy for 10 cycles per byte → bytes 00 00 11 00 00 27 in order, one done_tx, tx_start never during busy.
- N=8, all elements 255 → every result is 520200; on retr each result is sent as 07 F0 08.
- n_size=0, then n_size=9 → err and done_compute in cycle 1, no res_we and no RAM addresses toggled.
- start and retr in the same cycle → compute runs and retr is dropped. start during T_WAIT → ignored, and the transmission completes intact.
- reset during row 1 of an N=4 compute → all outputs 0 next cycle; a following retr → err and done_tx, no tx_start.

Source files
------------

// File: rtl/mxv_pkg.sv
// Shared types and defaults for the matrix-vector compute/retransmit sequencer.
package mxv_pkg;

  localparam int MAX_N_DEF  = 8;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 19;
  localparam int TX_BYTES   = 3;

  typedef enum logic [3:0] {
    IDLE, C_FETCH, C_DRAIN, C_WRITE, C_DONE,
    T_RD, T_LOAD, T_SEND, T_WAIT, T_DONE, ERR
  } state_t;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/mxv_mac.sv
// Unsigned multiplier feeding an accumulator register with clear/enable.
module mxv_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;

  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  always_ff @(posedge clk) begin
    if (reset || clr)
      acc <= '0;
    else if (en)
      acc <= acc + ACC_W'(prod);
  end

endmodule

// File: rtl/mxv_sequencer.sv
// PREPARE: N x N by N x 1 MAC into the result RAM. RETR: stream results
// to the UART TX, three bytes each, MSB first.
module mxv_sequencer
  import mxv_pkg::*;
#(
  parameter int MAX_N  = MAX_N_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             retr,
  input  logic [3:0]                       n_size,
  output logic [idx_w(MAX_N*MAX_N)-1:0]    mat_addr,
  input  logic [DATA_W-1:0]                mat_data,
  output logic [idx_w(MAX_N)-1:0]          vec_addr,
  input  logic [DATA_W-1:0]                vec_data,
  output logic [idx_w(MAX_N)-1:0]          res_addr,
  output logic                             res_we,
  output logic [ACC_W-1:0]                 res_wdata,
  input  logic [ACC_W-1:0]                 res_rdata,
  output logic                             tx_start,
  output logic [7:0]                       tx_data,
  input  logic                             tx_busy,
  output logic                             busy,
  output logic                             done_compute,
  output logic                             done_tx,
  output logic                             err
);

  localparam int MW   = idx_w(MAX_N*MAX_N);
  localparam int VW   = idx_w(MAX_N);
  localparam int BW   = idx_w(TX_BYTES);
  localparam int SR_W = 8*TX_BYTES;

  state_t            state, nxt;
  logic [VW-1:0]     row, col;
  logic [3:0]        n_lat;
  logic [BW-1:0]     byte_idx;
  logic [SR_W-1:0]   sr;
  logic              res_valid;
  logic              from_start;
  logic [ACC_W-1:0]  acc;
  logic              mac_clr, mac_en;
  logic              n_bad, last_col, last_row, last_byte;

  assign n_bad     = (n_size == 4'd0) || (n_size > 4'(MAX_N));
  assign last_col  = (4'(col) == n_lat - 4'd1);
  assign last_row  = (4'(row) == n_lat - 4'd1);
  assign last_byte = (byte_idx == BW'(TX_BYTES-1));

  mxv_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (mat_data),
    .b     (vec_data),
    .acc   (acc)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (start)     nxt = n_bad ? ERR : C_FETCH;
        else if (retr) nxt = res_valid ? T_RD : ERR;
      end
      C_FETCH: if (last_col) nxt = C_DRAIN;
      C_DRAIN: nxt = C_WRITE;
      C_WRITE: nxt = last_row ? C_DONE : C_FETCH;
      C_DONE:  nxt = IDLE;
      T_RD:    nxt = T_LOAD;
      T_LOAD:  nxt = T_SEND;
      T_SEND:  nxt = T_WAIT;
      T_WAIT: begin
        if (!tx_busy) begin
          if (!last_byte)    nxt = T_SEND;
          else if (last_row) nxt = T_DONE;
          else               nxt = T_RD;
        end
      end
      T_DONE:  nxt = IDLE;
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Moore outputs; the MAC controls ride along with the same decode.
  always_comb begin
    busy         = (state != IDLE);
    mat_addr     = '0;
    vec_addr     = '0;
    res_addr     = row;
    res_we       = 1'b0;
    res_wdata    = '0;
    tx_start     = 1'b0;
    tx_data      = '0;
    done_compute = 1'b0;
    done_tx      = 1'b0;
    err          = 1'b0;
    mac_clr      = 1'b0;
    mac_en       = 1'b0;
    case (state)
      IDLE:    mac_clr = start;
      C_FETCH: begin
        mat_addr = MW'(row) * MW'(MAX_N) + MW'(col);
        vec_addr = col;
        mac_en   = (col != '0);
      end
      C_DRAIN: mac_en = 1'b1;
      C_WRITE: begin
        res_we    = 1'b1;
        res_wdata = acc;
        mac_clr   = 1'b1;
      end
      C_DONE:  done_compute = 1'b1;
      T_SEND: begin
        tx_start = 1'b1;
        tx_data  = sr[SR_W-1 -: 8];
      end
      T_DONE:  done_tx = 1'b1;
      ERR: begin
        err          = 1'b1;
        done_compute = from_start;
        done_tx      = !from_start;
      end
      default: ;
    endcase
  end

  // Counters return to zero on the way back to IDLE so idle addresses stay quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      row        <= '0;
      col        <= '0;
      n_lat      <= '0;
      byte_idx   <= '0;
      sr         <= '0;
      res_valid  <= 1'b0;
      from_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_lat      <= n_size;
            res_valid  <= 1'b0;
            row        <= '0;
            col        <= '0;
            from_start <= 1'b1;
          end else if (retr) begin
            row        <= '0;
            from_start <= 1'b0;
          end
        end
        C_FETCH: col <= col + VW'(1);
        C_WRITE: begin
          col <= '0;
          row <= row + VW'(1);
        end
        C_DONE: begin
          res_valid <= 1'b1;
          row       <= '0;
        end
        T_LOAD: begin
          sr       <= SR_W'(res_rdata);
          byte_idx <= '0;
        end
        T_WAIT: begin
          if (!tx_busy) begin
            sr       <= sr << 8;
            byte_idx <= byte_idx + BW'(1);
            if (last_byte && !last_row) row <= row + VW'(1);
          end
        end
        T_DONE: row <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mxv_sequencer.sv
// Directed bench: RAM and UART TX models around the sequencer, table of uniform fills plus hand sequences.
module tb_mxv_sequencer;

  logic        clk, reset, start, retr;
  logic [3:0]  n_size;
  logic [5:0]  mat_addr;
  logic [7:0]  mat_data;
  logic [2:0]  vec_addr;
  logic [7:0]  vec_data;
  logic [2:0]  res_addr;
  logic        res_we;
  logic [18:0] res_wdata, res_rdata;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        busy, done_compute, done_tx, err;

  mxv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .retr(retr), .n_size(n_size),
    .mat_addr(mat_addr), .mat_data(mat_data), .vec_addr(vec_addr), .vec_data(vec_data),
    .res_addr(res_addr), .res_we(res_we), .res_wdata(res_wdata), .res_rdata(res_rdata),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .busy(busy),
    .done_compute(done_compute), .done_tx(done_tx), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mat_mem [64];
  logic [7:0]  vec_mem [8];
  logic [18:0] res_mem [8];
  logic [3:0]  bcnt;

  always @(posedge clk) begin
    mat_data  <= mat_mem[mat_addr];
    vec_data  <= vec_mem[vec_addr];
    if (res_we) res_mem[res_addr] <= res_wdata;
    res_rdata <= res_mem[res_addr];
  end

  // TX busy for 10 cycles per byte, rising the cycle after tx_start.
  always @(posedge clk) begin
    if (reset)         bcnt <= '0;
    else if (tx_start) bcnt <= 4'd10;
    else if (bcnt != 0) bcnt <= bcnt - 4'd1;
  end
  assign tx_busy = (bcnt != 0);

  int total = 0, bad = 0;
  logic [21:0] wr_q [$];
  logic [7:0]  tx_q [$];
  int ndtx, nerr, ndc, viol;
  logic addr_seen;

  typedef struct {
    logic [3:0]  n;
    logic [7:0]  mv;
    logic [7:0]  vv;
    logic        bad_n;
    int          dcyc;
    logic [18:0] res;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic clr_mon();
    wr_q.delete(); tx_q.delete();
    ndtx = 0; nerr = 0; ndc = 0; viol = 0; addr_seen = 1'b0;
  endtask

  // One cycle: land on the falling edge and record what the DUT shows.
  task automatic tick();
    @(negedge clk);
    if (res_we) wr_q.push_back({res_addr, res_wdata});
    if (tx_start) begin
      tx_q.push_back(tx_data);
      if (tx_busy) viol++;
    end
    if (done_tx) ndtx++;
    if (err) nerr++;
    if (done_compute) ndc++;
    if (mat_addr != 0 || vec_addr != 0 || res_addr != 0) addr_seen = 1'b1;
  endtask

  task automatic do_start(input logic [3:0] n, input logic with_retr, output int dcyc, output int ecyc);
    dcyc = -1; ecyc = -1;
    tick(); start = 1'b1; retr = with_retr; n_size = n;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k == 1) begin start = 1'b0; retr = 1'b0; n_size = 4'd3; end
      if (done_compute && dcyc < 0) dcyc = k;
      if (err && ecyc < 0) ecyc = k;
      if (!busy) break;
    end
    chk("start_timeout", {31'b0, busy}, 0);
  endtask

  task automatic do_retr(input logic inject, output int ecyc);
    ecyc = -1;
    tick(); retr = 1'b1;
    for (int k = 1; k <= 2000; k++) begin
      tick();
      if (k == 1) retr = 1'b0;
      if (inject && k == 5) begin start = 1'b1; n_size = 4'd1; end
      if (inject && k == 6) start = 1'b0;
      if (err && ecyc < 0) ecyc = k;
      if (!busy) break;
    end
    chk("retr_timeout", {31'b0, busy}, 0);
  endtask

  task automatic chk_bytes(input string nm, input int n, input logic [18:0] r0, input logic [18:0] r1, input logic uniform);
    logic [23:0] w;
    logic [7:0]  e;
    chk({nm, "_count"}, tx_q.size(), 3*n);
    for (int i = 0; i < 3*n; i++) begin
      w = {5'b0, (uniform || i < 3) ? r0 : r1};
      e = 8'(w >> (16 - 8*(i % 3)));
      chk(nm, (i < tx_q.size()) ? {24'b0, tx_q[i]} : 32'hDEAD, {24'b0, e});
    end
  endtask

  task automatic load_hand();
    mat_mem[0] = 8'd1; mat_mem[1] = 8'd2; mat_mem[8] = 8'd3; mat_mem[9] = 8'd4;
    vec_mem[0] = 8'd5; vec_mem[1] = 8'd6;
  endtask

  int dc, ec;

  initial begin
    tbl[0] = '{4'd8,  8'd255, 8'd255, 1'b0, 81, 19'd520200};
    tbl[1] = '{4'd1,  8'd7,   8'd9,   1'b0, 4,  19'd63};
    tbl[2] = '{4'd3,  8'd2,   8'd5,   1'b0, 16, 19'd30};
    tbl[3] = '{4'd0,  8'd1,   8'd1,   1'b1, 1,  19'd0};
    tbl[4] = '{4'd9,  8'd1,   8'd1,   1'b1, 1,  19'd0};
    tbl[5] = '{4'd15, 8'd1,   8'd1,   1'b1, 1,  19'd0};

    reset = 1'b1; start = 1'b0; retr = 1'b0; n_size = 4'd0;
    clr_mon();
    repeat (3) tick();
    chk("reset_ctrl", {22'b0, busy, res_we, tx_start, done_compute, done_tx, err, 4'b0}, 0);
    chk("reset_addr", {20'b0, mat_addr, vec_addr, res_addr}, 0);
    chk("reset_data", {5'b0, res_wdata, tx_data}, 0);
    reset = 1'b0;

    // Hand-computed 2x2 case and its retransmission.
    load_hand();
    clr_mon();
    do_start(4'd2, 1'b0, dc, ec);
    chk("n2_done_cyc", dc, 9);
    chk("n2_wr_count", wr_q.size(), 2);
    chk("n2_wr0", (wr_q.size() > 0) ? {10'b0, wr_q[0]} : 32'hDEAD, {10'b0, 3'd0, 19'd17});
    chk("n2_wr1", (wr_q.size() > 1) ? {10'b0, wr_q[1]} : 32'hDEAD, {10'b0, 3'd1, 19'd39});
    clr_mon();
    do_retr(1'b0, ec);
    chk_bytes("n2_byte", 2, 19'd17, 19'd39, 1'b0);
    chk("n2_done_tx", ndtx, 1);
    chk("n2_viol", viol, 0);
    chk("n2_err", nerr, 0);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 64; i++) mat_mem[i] = tbl[t].mv;
      for (int i = 0; i < 8; i++)  vec_mem[i] = tbl[t].vv;
      clr_mon();
      do_start(tbl[t].n, 1'b0, dc, ec);
      chk($sformatf("tbl%0d_done_cyc", t), dc, tbl[t].dcyc);
      if (tbl[t].bad_n) begin
        chk($sformatf("tbl%0d_err_cyc", t), ec, 1);
        chk($sformatf("tbl%0d_no_wr", t), wr_q.size(), 0);
        chk($sformatf("tbl%0d_addr_quiet", t), {31'b0, addr_seen}, 0);
        chk($sformatf("tbl%0d_no_dtx", t), ndtx, 0);
      end else begin
        chk($sformatf("tbl%0d_no_err", t), nerr, 0);
        chk($sformatf("tbl%0d_wr_count", t), wr_q.size(), tbl[t].n);
        for (int i = 0; i < tbl[t].n; i++)
          chk($sformatf("tbl%0d_wr%0d", t, i), (i < wr_q.size()) ? {10'b0, wr_q[i]} : 32'hDEAD,
              {10'b0, 3'(i), tbl[t].res});
        clr_mon();
        do_retr(1'b0, ec);
        chk_bytes($sformatf("tbl%0d_byte", t), tbl[t].n, tbl[t].res, tbl[t].res, 1'b1);
        chk($sformatf("tbl%0d_done_tx", t), ndtx, 1);
        chk($sformatf("tbl%0d_viol", t), viol, 0);
      end
    end

    // start and retr together: compute runs, retr is dropped.
    load_hand();
    clr_mon();
    do_start(4'd2, 1'b1, dc, ec);
    repeat (3) tick();
    chk("both_done_cyc", dc, 9);
    chk("both_wr_count", wr_q.size(), 2);
    chk("both_no_tx", tx_q.size(), 0);
    chk("both_no_dtx", ndtx, 0);
    chk("both_no_err", nerr, 0);

    // start during T_WAIT is ignored and the stream completes intact.
    clr_mon();
    do_retr(1'b1, ec);
    chk_bytes("inj_byte", 2, 19'd17, 19'd39, 1'b0);
    chk("inj_done_tx", ndtx, 1);
    chk("inj_no_dc", ndc, 0);
    chk("inj_no_wr", wr_q.size(), 0);
    chk("inj_viol", viol, 0);

    // Reset in row 1 of an N=4 compute.
    for (int i = 0; i < 64; i++) mat_mem[i] = 8'd1;
    clr_mon();
    tick(); start = 1'b1; n_size = 4'd4;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) start = 1'b0;
    end
    chk("rst_row1_addr", {26'b0, mat_addr}, 9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_ctrl", {26'b0, busy, res_we, tx_start, done_compute, done_tx, err}, 0);
    chk("rst_addr", {20'b0, mat_addr, vec_addr, res_addr}, 0);
    chk("rst_data", {5'b0, res_wdata, tx_data}, 0);
    chk("rst_wr_count", wr_q.size(), 1);
    clr_mon();
    do_retr(1'b0, ec);
    chk("rst_retr_err_cyc", ec, 1);
    chk("rst_retr_dtx", ndtx, 1);
    chk("rst_retr_no_tx", tx_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
